fetch_sequencer: RTL

- Controller that owns and sequences the RV32I program counter for the single-cycle-style core.
- Issues one instruction-memory read per PC value and presents the fetched word to decode with a valid/ready handshake.
- Applies PC+4, branch/jump redirects and trap entry, with defined priority.
- Guarantees at most one outstanding memory read; squashes stale responses after a redirect.

---
 rtl/fetch_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// RV32I fetch sequencer: owns the PC, issues one imem read at a time and hands
// the fetched word to decode; redirects and traps squash any in-flight read.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  output logic        misalign_fault,
  output logic [31:0] pc_current
);

  // state | meaning
  // BOOT  | one idle cycle after reset
  // REQ   | read of pc_q outstanding, waiting for imem_rvalid
  // VALID | captured instruction offered to decode
  // DRAIN | squashed read still in flight, waiting to discard its response
  typedef enum logic [1:0] {BOOT, REQ, VALID, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        misalign_q, misalign_d;
  logic        event_hit;
  logic [31:0] target;

  // Trap outranks redirect, so a misaligned redirect under a trap raises no fault.
  always_comb begin
    event_hit  = trap_valid | redirect_valid;
    misalign_d = redirect_valid & ~trap_valid & (redirect_target[1:0] != 2'b00);
    if (trap_valid || misalign_d) target = TRAP_VECTOR;
    else                          target = redirect_target;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      BOOT: begin
        if (event_hit) pc_d = target;
        state_d = REQ;
      end
      REQ: begin
        if (event_hit) begin
          pc_d    = target;
          state_d = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (event_hit) begin
          pc_d    = target;
          state_d = REQ;
        end else if (instr_ready) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (event_hit) pc_d = target;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req       = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == VALID);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign misalign_fault = misalign_q;
  assign pc_current     = pc_q;

endmodule
